expr_sig_collector: RTL and testbench



---
 rtl/expr_sig_collector_pkg.sv | 26 ++
 rtl/expr_sig_collector_if.sv | 18 +
 rtl/expr_sig_collector_misr_step.sv | 26 ++
 rtl/expr_sig_collector.sv | 118 +++++++++++
 tb/tb_expr_sig_collector.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/expr_sig_collector_pkg.sv
// ----------------------------------------------------------------------------
// expr_sig_pkg : shared types, constants and the 90-bit fold for the collector
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package expr_sig_pkg;

    localparam int          SIG_W    = 32;
    localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEF_SEED = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sig_state_t;

    // Caller zero-extends the result word to 96 bits before folding.
    function automatic logic [SIG_W-1:0] fold90(input logic [95:0] d);
        return d[31:0] ^ d[63:32] ^ d[95:64];
    endfunction

endpackage

`default_nettype wire

// File: rtl/expr_sig_collector_if.sv
// ----------------------------------------------------------------------------
// expr_sig_if : valid/ready result-word channel into the signature collector
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface expr_sig_if #(
    parameter int DATA_W = 90
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

`default_nettype wire

// File: rtl/expr_sig_collector_misr_step.sv
// ----------------------------------------------------------------------------
// expr_sig_misr_step : one combinational MISR update (sig, data) -> sig'
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module expr_sig_misr_step
    import expr_sig_pkg::*;
#(
    parameter int          DATA_W = 90,
    parameter logic [31:0] POLY   = DEF_POLY
) (
    input  wire logic [SIG_W-1:0]  sig_i,
    input  wire logic [DATA_W-1:0] data_i,
    output logic      [SIG_W-1:0]  sig_o
);
    logic [95:0]      ext_w;
    logic [SIG_W-1:0] fold_w;

    assign ext_w  = 96'(data_i);
    assign fold_w = fold90(ext_w);
    assign sig_o  = {sig_i[SIG_W-2:0], 1'b0} ^ (sig_i[SIG_W-1] ? POLY : '0) ^ fold_w;

endmodule

`default_nettype wire

// File: rtl/expr_sig_collector.sv
// ----------------------------------------------------------------------------
// expr_sig_collector : compresses a fixed-length run of result words into a
// MISR signature and flags pass/fail against a captured golden value. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module expr_sig_collector
    import expr_sig_pkg::*;
#(
    parameter int          DATA_W    = 90,
    parameter int          N_SAMPLES = 256,
    parameter logic [31:0] POLY      = DEF_POLY,
    parameter logic [31:0] SEED      = DEF_SEED
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic             abort,
    input  wire logic [SIG_W-1:0] expected_sig,
    expr_sig_if.slave             in_if,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic      [SIG_W-1:0] signature,
    output logic      [15:0]      count
);
    localparam logic [15:0] LAST_IDX = 16'(N_SAMPLES - 1);

    sig_state_t       state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [SIG_W-1:0] exp_q, exp_d;
    logic [15:0]      count_q, count_d;
    logic             pass_q, pass_d;
    logic [SIG_W-1:0] step_w;
    logic             accept_w;

    expr_sig_misr_step #(
        .DATA_W (DATA_W),
        .POLY   (POLY)
    ) u_step (
        .sig_i  (sig_q),
        .data_i (in_if.in_data),
        .sig_o  (step_w)
    );

    assign in_if.in_ready = (state_q == RUN);
    // Abort wins over a coinciding handshake: the word is dropped.
    assign accept_w = in_if.in_valid && (state_q == RUN) && !abort;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        exp_d   = exp_q;
        count_d = count_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = RUN;
                    sig_d   = SEED;
                    count_d = '0;
                    exp_d   = expected_sig;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (accept_w) begin
                    sig_d   = step_w;
                    count_d = count_q + 16'd1;
                    if (count_q == LAST_IDX) begin
                        state_d = DONE;
                        pass_d  = (step_w == exp_q);
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (start) begin
                    state_d = RUN;
                    sig_d   = SEED;
                    count_d = '0;
                    exp_d   = expected_sig;
                    pass_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sig_q   <= '0;
            exp_q   <= '0;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            exp_q   <= exp_d;
            count_q <= count_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign signature = sig_q;
    assign count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_expr_sig_collector.sv
// ----------------------------------------------------------------------------
// tb_expr_sig_collector : directed + random bench for three run lengths
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_expr_sig_collector;
    localparam int          DW    = 90;
    localparam logic [31:0] PPOLY = 32'h04C11DB7;
    localparam logic [31:0] PSEED = 32'hFFFFFFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, valid;
    logic [31:0]   expected;
    logic [DW-1:0] data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    expr_sig_if #(.DATA_W(DW)) if1 ();
    expr_sig_if #(.DATA_W(DW)) if4 ();
    expr_sig_if #(.DATA_W(DW)) if256 ();

    assign if1.in_valid   = valid;
    assign if1.in_data    = data;
    assign if4.in_valid   = valid;
    assign if4.in_data    = data;
    assign if256.in_valid = valid;
    assign if256.in_data  = data;

    logic        busy1, done1, pass1, busy4, done4, pass4, busy256, done256, pass256;
    logic [31:0] sig1, sig4, sig256;
    logic [15:0] cnt1, cnt4, cnt256;

    expr_sig_collector #(.DATA_W(DW), .N_SAMPLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected_sig(expected),
        .in_if(if1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .count(cnt1));
    expr_sig_collector #(.DATA_W(DW), .N_SAMPLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected_sig(expected),
        .in_if(if4), .busy(busy4), .done(done4), .pass(pass4), .signature(sig4), .count(cnt4));
    expr_sig_collector #(.DATA_W(DW), .N_SAMPLES(256)) dut256 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected_sig(expected),
        .in_if(if256), .busy(busy256), .done(done256), .pass(pass256), .signature(sig256),
        .count(cnt256));

    // Reference: the signature is sig*x mod P plus the folded word, in GF(2).
    function automatic logic [31:0] m_fold(input logic [DW-1:0] d);
        logic [95:0] z;
        logic [31:0] r;
        z = 96'(d);
        r = '0;
        for (int k = 0; k < 3; k++) r = r ^ z[k*32 +: 32];
        return r;
    endfunction

    function automatic logic [31:0] m_step(input logic [31:0] s, input logic [DW-1:0] d);
        logic [32:0] t;
        t = {s, 1'b0};
        if (t[32]) t = t ^ {1'b1, PPOLY};
        return t[31:0] ^ m_fold(d);
    endfunction

    function automatic logic [DW-1:0] rnd90();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] words[256];
    logic [31:0]   s, gold;
    int            k;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0;
        expected = '0; data = '0;
        tick(); tick();
        chk("rst_sig", sig1, 32'h0);
        chk("rst_cnt", 32'(cnt1), 32'h0);
        chk("rst_busy", 32'(busy1), 32'h0);
        chk("rst_done", 32'(done1), 32'h0);
        chk("rst_pass", 32'(pass1), 32'h0);
        chk("rst_rdy", 32'(if1.in_ready), 32'h0);
        rst_n = 1'b1;
        tick();

        // single zero word, N=1
        start = 1'b1; expected = 32'hFB3EE249;
        tick();
        start = 1'b0;
        chk("n1_rdy", 32'(if1.in_ready), 32'h1);
        chk("n1_seed", sig1, PSEED);
        valid = 1'b1; data = '0;
        tick();
        valid = 1'b0;
        chk("n1_sig", sig1, 32'hFB3EE249);
        chk("n1_cnt", 32'(cnt1), 32'h1);
        chk("n1_done", 32'(done1), 32'h1);
        chk("n1_pass", 32'(pass1), 32'h1);
        chk("n1_rdy_done", 32'(if1.in_ready), 32'h0);

        // restart from DONE with a wrong golden value
        start = 1'b1; expected = 32'h0;
        tick();
        start = 1'b0;
        chk("mm_pass_clr", 32'(pass1), 32'h0);
        chk("mm_reload", sig1, PSEED);
        chk("mm_cnt_clr", 32'(cnt1), 32'h0);
        valid = 1'b1; data = '0;
        tick();
        valid = 1'b0;
        chk("mm_done", 32'(done1), 32'h1);
        chk("mm_pass", 32'(pass1), 32'h0);

        // back-pressure, N=4
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        s = PSEED;
        for (int i = 0; i < 4; i++) begin
            words[i] = rnd90();
            s = m_step(s, words[i]);
        end
        gold = s;
        start = 1'b1; expected = gold;
        tick();
        start = 1'b0;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            valid = (i % 2 == 0);
            data  = valid ? words[k] : rnd90();
            tick();
            if (i % 2 == 0) k++;
            chk("bp_cnt", 32'(cnt4), 32'(k));
            chk("bp_done", 32'(done4), 32'(k == 4));
        end
        valid = 1'b0;
        chk("bp_sig", sig4, gold);
        chk("bp_pass", 32'(pass4), 32'h1);

        // abort together with a handshake at count=2
        start = 1'b1; tick(); start = 1'b0;
        s = PSEED;
        for (int i = 0; i < 2; i++) begin
            valid = 1'b1; data = rnd90();
            s = m_step(s, data);
            tick();
        end
        abort = 1'b1; data = rnd90();
        tick();
        abort = 1'b0; valid = 1'b0;
        chk("ab_busy", 32'(busy4), 32'h0);
        chk("ab_done", 32'(done4), 32'h0);
        chk("ab_cnt", 32'(cnt4), 32'h2);
        chk("ab_sig", sig4, s);
        chk("ab_rdy", 32'(if4.in_ready), 32'h0);
        chk("ab_pass", 32'(pass4), 32'h0);

        // start pulsed in RUN is ignored
        start = 1'b1; tick(); start = 1'b0;
        s = PSEED;
        valid = 1'b1; data = rnd90(); s = m_step(s, data);
        tick();
        valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("si_cnt", 32'(cnt4), 32'h1);
        chk("si_sig", sig4, s);
        valid = 1'b1; data = rnd90(); s = m_step(s, data);
        tick();
        valid = 1'b0;
        chk("si_cnt2", 32'(cnt4), 32'h2);
        chk("si_sig2", sig4, s);
        chk("si_busy", 32'(busy4), 32'h1);

        // asynchronous reset mid-run
        #2 rst_n = 1'b0;
        #1;
        chk("ar_sig", sig4, 32'h0);
        chk("ar_cnt", 32'(cnt4), 32'h0);
        chk("ar_busy", 32'(busy4), 32'h0);
        chk("ar_rdy", 32'(if4.in_ready), 32'h0);
        tick(); rst_n = 1'b1; tick();
        chk("ar_stay_idle", 32'(busy4), 32'h0);

        // random regression, N=256, valid held high
        s = PSEED;
        for (int i = 0; i < 256; i++) begin
            words[i] = rnd90();
            s = m_step(s, words[i]);
        end
        gold = s;
        start = 1'b1; expected = gold;
        tick();
        start = 1'b0;
        chk("rr_rdy", 32'(if256.in_ready), 32'h1);
        valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            data = words[i];
            if (i == 255) chk("rr_not_done", 32'(done256), 32'h0);
            tick();
        end
        valid = 1'b0;
        chk("rr_done", 32'(done256), 32'h1);
        chk("rr_cnt", 32'(cnt256), 32'd256);
        chk("rr_sig", sig256, gold);
        chk("rr_pass", 32'(pass256), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
